multdiv_sequencer: RTL and testbench

Controls the multi-cycle multiply/divide unit on behalf of the 5-stage pipeline. It detects a mult/div in DX, captures the operands and destination register, and pulses ctrl_MULT/ctrl_DIV to the multdiv unit. While the unit runs, it stalls PC/FD/DX. It then hands the result, or an rstatus exception value, to the XM latch for exactly one cycle.

---
 rtl/multdiv_sequencer_pkg.sv | 25 ++
 rtl/multdiv_sequencer_if.sv | 33 +++
 rtl/multdiv_sequencer_md_timeout_counter.sv | 26 ++
 rtl/multdiv_sequencer.sv | 129 ++++++++++++
 tb/tb_multdiv_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the mult/div sequencer: FSM encoding, opcodes and
// the rstatus codes written to r30 when an operation ends in an exception.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } md_state_t;

    localparam logic [4:0]  MULT_OP         = 5'b00110;
    localparam logic [4:0]  DIV_OP          = 5'b00111;

    localparam logic [31:0] RSTATUS_MULT    = 32'd4;
    localparam logic [31:0] RSTATUS_DIV     = 32'd5;
    localparam logic [31:0] RSTATUS_TIMEOUT = 32'd7;
    localparam logic [4:0]  RSTATUS_REG     = 5'd30;

    // rstatus code reported when the multdiv unit itself flags an exception
    function automatic logic [31:0] rstatus_for_op(input logic is_div);
        return is_div ? RSTATUS_DIV : RSTATUS_MULT;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the multi-cycle
// multdiv unit (slave).
interface multdiv_sequencer_if;

    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;

    modport master (
        output md_operand_a,
        output md_operand_b,
        output ctrl_MULT,
        output ctrl_DIV,
        input  md_result,
        input  md_exception,
        input  md_resultRDY
    );

    modport slave (
        input  md_operand_a,
        input  md_operand_b,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output md_result,
        output md_exception,
        output md_resultRDY
    );

endinterface

// File: rtl/multdiv_sequencer_md_timeout_counter.sv
// Counts cycles spent waiting on the multdiv unit; terminal flags the last
// cycle the sequencer is willing to wait before forcing completion.
module md_timeout_counter #(
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues mult/div operations from DX to the multdiv unit, stalls the front
// of the pipeline while it runs, and delivers one result (or rstatus) to XM.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dx_is_mult,
    input  logic                 dx_is_div,
    input  logic [31:0]          dx_operand_a,
    input  logic [31:0]          dx_operand_b,
    input  logic [4:0]           dx_rd,
    input  logic                 flush,
    multdiv_sequencer_if.master  md,
    output logic                 stall,
    output logic                 result_valid,
    output logic [31:0]          result,
    output logic [4:0]           result_rd,
    output logic                 exception
);

    md_state_t state;
    md_state_t next_state;

    logic       start;
    logic       counter_clear;
    logic       counter_enable;
    logic       timeout_hit;
    logic [4:0] rd_q;
    logic       op_is_div;

    assign start = (dx_is_mult | dx_is_div) & ~flush & (state == IDLE);
    assign stall = start | (state == ISSUE) | (state == BUSY);

    md_timeout_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (counter_clear),
        .enable   (counter_enable),
        .terminal (timeout_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush beats a same-cycle RDY in ISSUE/BUSY; DONE always completes.
    always_comb begin
        next_state     = state;
        counter_clear  = 1'b0;
        counter_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                counter_clear = 1'b1;
                next_state    = flush ? IDLE : BUSY;
            end
            BUSY: begin
                counter_enable = 1'b1;
                if (flush) begin
                    next_state = IDLE;
                end else if (md.md_resultRDY || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Mult takes priority when DX decodes both; result fields persist
    // between completions so XM can read them in the DONE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            md.md_operand_a <= '0;
            md.md_operand_b <= '0;
            md.ctrl_MULT    <= 1'b0;
            md.ctrl_DIV     <= 1'b0;
            rd_q            <= '0;
            op_is_div       <= 1'b0;
            result_valid    <= 1'b0;
            result          <= '0;
            result_rd       <= '0;
            exception       <= 1'b0;
        end else begin
            md.ctrl_MULT <= start & dx_is_mult;
            md.ctrl_DIV  <= start & ~dx_is_mult;
            result_valid <= (state == BUSY) && (next_state == DONE);

            if (start) begin
                md.md_operand_a <= dx_operand_a;
                md.md_operand_b <= dx_operand_b;
                rd_q            <= dx_rd;
                op_is_div       <= ~dx_is_mult;
            end

            if ((state == BUSY) && !flush) begin
                if (md.md_resultRDY) begin
                    exception <= md.md_exception;
                    result    <= md.md_exception ? rstatus_for_op(op_is_div) : md.md_result;
                    result_rd <= md.md_exception ? RSTATUS_REG : rd_q;
                end else if (timeout_hit) begin
                    exception <= 1'b1;
                    result    <= RSTATUS_TIMEOUT;
                    result_rd <= RSTATUS_REG;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: the bench plays the multdiv unit and
// scoreboards every result_valid pulse against expected XM writes.
module tb_multdiv_sequencer;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        exc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        dx_is_mult;
    logic        dx_is_div;
    logic [31:0] dx_operand_a;
    logic [31:0] dx_operand_b;
    logic [4:0]  dx_rd;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        exception;

    exp_t sb[$];
    int   tests       = 0;
    int   failed      = 0;
    int   stall_cnt   = 0;
    int   mult_pulses = 0;
    int   div_pulses  = 0;

    multdiv_sequencer_if md_bus ();

    multdiv_sequencer #(
        .TIMEOUT (64),
        .CNT_W   (7)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dx_is_mult   (dx_is_mult),
        .dx_is_div    (dx_is_div),
        .dx_operand_a (dx_operand_a),
        .dx_operand_b (dx_operand_b),
        .dx_rd        (dx_rd),
        .flush        (flush),
        .md           (md_bus.master),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .result_rd    (result_rd),
        .exception    (exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample on the falling edge, then move inputs just past the rising edge
    task automatic step();
        exp_t e;
        @(negedge clock);
        if (stall === 1'b1) stall_cnt++;
        if (md_bus.ctrl_MULT === 1'b1) mult_pulses++;
        if (md_bus.ctrl_DIV === 1'b1) div_pulses++;
        if (result_valid !== 1'b0) begin
            tests++;
            assert (sb.size() != 0)
            else begin
                failed++;
                $error("[TB] FAIL unexpected_result_valid observed=%b expected=0", result_valid);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("result", result, e.result);
                checkOutput("result_rd", 32'(result_rd), 32'(e.rd));
                checkOutput("exception", 32'(exception), 32'(e.exc));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clearCounters();
        stall_cnt   = 0;
        mult_pulses = 0;
        div_pulses  = 0;
    endtask

    // Present an op in DX for the accept cycle, clear DX, ride through ISSUE
    task automatic applyStimulus(input logic m, input logic d, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        dx_is_mult   = m;
        dx_is_div    = d;
        dx_operand_a = a;
        dx_operand_b = b;
        dx_rd        = rd;
        step();
        dx_is_mult = 1'b0;
        dx_is_div  = 1'b0;
        step();
    endtask

    // Called at BUSY cycle 1; raises RDY in BUSY cycle n
    task automatic respond(input int n, input logic [31:0] res, input logic exc);
        for (int i = 1; i < n; i++) step();
        md_bus.md_resultRDY = 1'b1;
        md_bus.md_result    = res;
        md_bus.md_exception = exc;
        step();
        md_bus.md_resultRDY = 1'b0;
        md_bus.md_exception = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        dx_is_mult          = 1'b0;
        dx_is_div           = 1'b0;
        dx_operand_a        = '0;
        dx_operand_b        = '0;
        dx_rd               = '0;
        flush               = 1'b0;
        md_bus.md_result    = '0;
        md_bus.md_exception = 1'b0;
        md_bus.md_resultRDY = 1'b0;

        step();
        step();
        checkOutput("reset_stall", 32'(stall), 0);
        checkOutput("reset_result_valid", 32'(result_valid), 0);
        checkOutput("reset_ctrl", 32'({md_bus.ctrl_MULT, md_bus.ctrl_DIV}), 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_exception", 32'(exception), 0);
        reset = 1'b0;
        step();

        // mult 7*6, RDY in BUSY cycle 17
        clearCounters();
        sb.push_back('{result: 32'd42, rd: 5'd9, exc: 1'b0});
        applyStimulus(1'b1, 1'b0, 32'd7, 32'd6, 5'd9);
        checkOutput("mult_operand_a", md_bus.md_operand_a, 32'd7);
        checkOutput("mult_operand_b", md_bus.md_operand_b, 32'd6);
        respond(17, 32'd42, 1'b0);
        step();
        checkOutput("mult_stall_cycles", 32'(stall_cnt), 32'd19);
        checkOutput("mult_ctrl_MULT_pulses", 32'(mult_pulses), 32'd1);
        checkOutput("mult_ctrl_DIV_pulses", 32'(div_pulses), 32'd0);
        checkOutput("mult_sb_drained", 32'(sb.size()), 0);

        // div 100/0 with exception at RDY
        clearCounters();
        sb.push_back('{result: 32'd5, rd: 5'd30, exc: 1'b1});
        applyStimulus(1'b0, 1'b1, 32'd100, 32'd0, 5'd12);
        respond(5, 32'hDEAD_BEEF, 1'b1);
        step();
        checkOutput("div0_ctrl_DIV_pulses", 32'(div_pulses), 32'd1);
        checkOutput("div0_ctrl_MULT_pulses", 32'(mult_pulses), 32'd0);
        checkOutput("div0_sb_drained", 32'(sb.size()), 0);

        // timeout: RDY never arrives
        clearCounters();
        sb.push_back('{result: 32'd7, rd: 5'd30, exc: 1'b1});
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 5'd4);
        for (int i = 0; i < 64; i++) step();
        checkOutput("timeout_stall_cycles", 32'(stall_cnt), 32'd66);
        step();
        checkOutput("timeout_sb_drained", 32'(sb.size()), 0);
        md_bus.md_resultRDY = 1'b1;
        md_bus.md_result    = 32'd99;
        step();
        step();
        md_bus.md_resultRDY = 1'b0;
        checkOutput("stray_rdy_stall", 32'(stall_cnt), 32'd66);
        checkOutput("stray_rdy_result_held", result, 32'd7);

        // flush in BUSY cycle 5, then late RDY
        clearCounters();
        applyStimulus(1'b1, 1'b0, 32'd11, 32'd13, 5'd3);
        for (int i = 1; i < 5; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flush_stall_low", 32'(stall), 0);
        md_bus.md_resultRDY = 1'b1;
        md_bus.md_result    = 32'd143;
        step();
        step();
        md_bus.md_resultRDY = 1'b0;
        checkOutput("flush_stall_cycles", 32'(stall_cnt), 32'd7);
        checkOutput("flush_result_held", result, 32'd7);

        // normal mult after the flush
        sb.push_back('{result: 32'd25, rd: 5'd8, exc: 1'b0});
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd5, 5'd8);
        respond(3, 32'd25, 1'b0);
        step();
        checkOutput("post_flush_sb_drained", 32'(sb.size()), 0);

        // reset during BUSY
        applyStimulus(1'b1, 1'b0, 32'd2, 32'd2, 5'd1);
        step();
        reset = 1'b1;
        step();
        checkOutput("busy_reset_stall", 32'(stall), 0);
        checkOutput("busy_reset_ctrl", 32'({md_bus.ctrl_MULT, md_bus.ctrl_DIV}), 0);
        checkOutput("busy_reset_result_valid", 32'(result_valid), 0);
        checkOutput("busy_reset_exception", 32'(exception), 0);
        checkOutput("busy_reset_result", result, 0);
        reset = 1'b0;
        step();

        // back-to-back: mult held in DX through DONE, div follows immediately
        clearCounters();
        sb.push_back('{result: 32'd72, rd: 5'd5, exc: 1'b0});
        sb.push_back('{result: 32'd9, rd: 5'd6, exc: 1'b0});
        dx_is_mult   = 1'b1;
        dx_operand_a = 32'd9;
        dx_operand_b = 32'd8;
        dx_rd        = 5'd5;
        step();
        step();
        respond(4, 32'd72, 1'b0);
        step();
        dx_is_mult   = 1'b0;
        dx_is_div    = 1'b1;
        dx_operand_a = 32'd81;
        dx_operand_b = 32'd9;
        dx_rd        = 5'd6;
        checkOutput("b2b_stall_on_accept", 32'(stall), 1);
        step();
        checkOutput("b2b_operand_a", md_bus.md_operand_a, 32'd81);
        checkOutput("b2b_operand_b", md_bus.md_operand_b, 32'd9);
        step();
        dx_is_div = 1'b0;
        respond(3, 32'd9, 1'b0);
        step();
        checkOutput("b2b_mult_pulses", 32'(mult_pulses), 32'd1);
        checkOutput("b2b_div_pulses", 32'(div_pulses), 32'd1);
        checkOutput("b2b_sb_drained", 32'(sb.size()), 0);

        // mult and div both decoded: mult wins
        clearCounters();
        sb.push_back('{result: 32'd9, rd: 5'd2, exc: 1'b0});
        applyStimulus(1'b1, 1'b1, 32'd3, 32'd3, 5'd2);
        respond(2, 32'd9, 1'b0);
        step();
        checkOutput("both_mult_pulses", 32'(mult_pulses), 32'd1);
        checkOutput("both_div_pulses", 32'(div_pulses), 32'd0);
        checkOutput("both_sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
